stat_test_window: RTL

- Parametrised successor to the fixed 1M-bit frequency test in the TRNG health-check path.
- Gates the TRO through enable_TRO and consumes WORD_W-bit random words.
- Runs two window tests over a sample of SAMPLE_WORDS words: monobit count and 0→1 transition count. Each test's window comes from runtime threshold ports.
- Supports start/restart without reset, a continuous auto-restart mode, per-test fail flags and a saturating failed-sample counter.

---
 rtl/stat_test_pkg.sv | 22 ++
 rtl/stat_popcount.sv | 33 +++
 rtl/stat_test_window.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/stat_test_pkg.sv
// Shared types and helpers for the stat_test_window health-check block.
package stat_test_pkg;

  // Sample-level sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_EVAL    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Bit positions inside test_en / fail_flags.
  localparam int MONOBIT = 0;
  localparam int TRANS   = 1;

  // Accumulator width able to hold a full-sample count (0..words*word_w).
  function automatic int cnt_width(input int words, input int word_w);
    return $clog2(words * word_w + 1);
  endfunction

endpackage

// File: rtl/stat_popcount.sv
// Combinational population count built as a balanced binary adder tree.
module stat_popcount
  import stat_test_pkg::*;
#(
  parameter int WORD_W = 64,
  parameter int OUT_W  = $clog2(WORD_W + 1)
) (
  input  logic [WORD_W-1:0] word,
  output logic [OUT_W-1:0]  count
);

  // Leaves are padded up to a power of two so every level halves cleanly.
  localparam int LEVELS = $clog2(WORD_W);
  localparam int LEAVES = 1 << LEVELS;

  for (genvar lv = 0; lv <= LEVELS; lv++) begin : g_lvl
    logic [OUT_W-1:0] sum [LEAVES >> lv];
    for (genvar gi = 0; gi < (LEAVES >> lv); gi++) begin : g_node
      if (lv == 0) begin : g_leaf
        if (gi < WORD_W) begin : g_bit
          assign sum[gi] = OUT_W'(word[gi]);
        end else begin : g_pad
          assign sum[gi] = '0;
        end
      end else begin : g_add
        assign sum[gi] = g_lvl[lv-1].sum[2*gi] + g_lvl[lv-1].sum[2*gi+1];
      end
    end
  end

  assign count = g_lvl[LEVELS].sum[0];

endmodule

// File: rtl/stat_test_window.sv
// Windowed monobit and 0->1 transition health test over a sample of random words.
module stat_test_window
  import stat_test_pkg::*;
#(
  parameter int WORD_W       = 64,
  parameter int SAMPLE_WORDS = 15625,
  parameter int CNT_W        = cnt_width(SAMPLE_WORDS, WORD_W),
  parameter int FCNT_W       = 8
) (
  input  logic              clk,
  input  logic              stat_trng_rst_n,
  input  logic              start,
  input  logic              cont_mode,
  input  logic [1:0]        test_en,
  input  logic [CNT_W-1:0]  ones_lo,
  input  logic [CNT_W-1:0]  ones_hi,
  input  logic [CNT_W-1:0]  trans_lo,
  input  logic [CNT_W-1:0]  trans_hi,
  input  logic [WORD_W-1:0] random_reg,
  input  logic              rng_valid,
  output logic              enable_TRO,
  output logic              done,
  output logic              stat_error,
  output logic [1:0]        fail_flags,
  output logic [FCNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0]  debug_ones,
  output logic [CNT_W-1:0]  debug_trans
);

  localparam int POP_W = $clog2(WORD_W + 1);
  localparam int WC_W  = $clog2(SAMPLE_WORDS + 1);

  state_t             state_reg, state_next;
  logic               start_go;        // any sample start, explicit or auto-restart
  logic               start_explicit;  // start pulse honoured: re-latch config
  logic               accept;
  logic               last_accept;
  logic [WC_W-1:0]    word_cnt_reg;
  logic               prev_bit_reg;
  logic [WORD_W-1:0]  b01;
  logic [POP_W-1:0]   pop_ones, pop_b01;
  logic [POP_W-1:0]   pc_ones_reg, pc_trans_reg;
  logic               stage1_vld_reg;
  logic [CNT_W-1:0]   ones_acc_reg, trans_acc_reg;
  logic [1:0]         test_en_reg;
  logic [CNT_W-1:0]   ones_lo_reg, ones_hi_reg, trans_lo_reg, trans_hi_reg;
  logic [1:0]         fail_next;
  logic [1:0]         fail_flags_reg;
  logic               done_reg;
  logic [FCNT_W-1:0]  fail_cnt_reg;

  assign accept      = (state_reg == ST_COLLECT) && rng_valid &&
                       (word_cnt_reg < WC_W'(SAMPLE_WORDS));
  assign last_accept = accept && (word_cnt_reg == WC_W'(SAMPLE_WORDS - 1));

  // A 0->1 transition lands on bit i when bit i is 1 and its MSB-side neighbour is 0;
  // the neighbour of the MSB is the last bit of the previous word.
  assign b01 = ~{prev_bit_reg, random_reg[WORD_W-1:1]} & random_reg;

  stat_popcount #(.WORD_W(WORD_W)) u_pop_ones (.word(random_reg), .count(pop_ones));
  stat_popcount #(.WORD_W(WORD_W)) u_pop_b01  (.word(b01),        .count(pop_b01));

  assign fail_next[MONOBIT] = test_en_reg[MONOBIT] &
                              ((ones_acc_reg < ones_lo_reg) | (ones_acc_reg > ones_hi_reg));
  assign fail_next[TRANS]   = test_en_reg[TRANS] &
                              ((trans_acc_reg < trans_lo_reg) | (trans_acc_reg > trans_hi_reg));

  // State register.
  always_ff @(posedge clk or negedge stat_trng_rst_n) begin
    if (!stat_trng_rst_n) state_reg <= ST_IDLE;
    else                  state_reg <= state_next;
  end

  // Next-state decode; start is only honoured from IDLE or DONE.
  always_comb begin
    state_next     = state_reg;
    start_go       = 1'b0;
    start_explicit = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          start_go       = 1'b1;
          start_explicit = 1'b1;
          state_next     = ST_COLLECT;
        end
      end
      ST_COLLECT: if (last_accept) state_next = ST_FLUSH;
      ST_FLUSH:   state_next = ST_EVAL;
      ST_EVAL:    state_next = ST_DONE;
      ST_DONE: begin
        if (start || cont_mode) begin
          start_go       = 1'b1;
          start_explicit = start;
          state_next     = ST_COLLECT;
        end
      end
      default:    state_next = ST_IDLE;
    endcase
  end

  // Word counter and the stream bit carried between consecutive words.
  always_ff @(posedge clk or negedge stat_trng_rst_n) begin
    if (!stat_trng_rst_n) begin
      word_cnt_reg <= '0;
      prev_bit_reg <= 1'b1;
    end else if (start_go) begin
      word_cnt_reg <= '0;
      prev_bit_reg <= 1'b1;
    end else if (accept) begin
      word_cnt_reg <= word_cnt_reg + WC_W'(1);
      prev_bit_reg <= random_reg[0];
    end
  end

  // Stage 1: register per-word popcounts.
  always_ff @(posedge clk or negedge stat_trng_rst_n) begin
    if (!stat_trng_rst_n) begin
      pc_ones_reg    <= '0;
      pc_trans_reg   <= '0;
      stage1_vld_reg <= 1'b0;
    end else begin
      stage1_vld_reg <= accept;
      if (accept) begin
        pc_ones_reg  <= pop_ones;
        pc_trans_reg <= pop_b01;
      end
    end
  end

  // Stage 2: sample accumulators.
  always_ff @(posedge clk or negedge stat_trng_rst_n) begin
    if (!stat_trng_rst_n) begin
      ones_acc_reg  <= '0;
      trans_acc_reg <= '0;
    end else if (start_go) begin
      ones_acc_reg  <= '0;
      trans_acc_reg <= '0;
    end else if (stage1_vld_reg) begin
      ones_acc_reg  <= ones_acc_reg + CNT_W'(pc_ones_reg);
      trans_acc_reg <= trans_acc_reg + CNT_W'(pc_trans_reg);
    end
  end

  // Configuration snapshot taken only on an explicit start; auto-restart reuses it.
  always_ff @(posedge clk or negedge stat_trng_rst_n) begin
    if (!stat_trng_rst_n) begin
      test_en_reg  <= '0;
      ones_lo_reg  <= '0;
      ones_hi_reg  <= '0;
      trans_lo_reg <= '0;
      trans_hi_reg <= '0;
    end else if (start_explicit) begin
      test_en_reg  <= test_en;
      ones_lo_reg  <= ones_lo;
      ones_hi_reg  <= ones_hi;
      trans_lo_reg <= trans_lo;
      trans_hi_reg <= trans_hi;
    end
  end

  // Verdict registers: flags, done and the saturating fail counter update together.
  always_ff @(posedge clk or negedge stat_trng_rst_n) begin
    if (!stat_trng_rst_n) begin
      fail_flags_reg <= '0;
      done_reg       <= 1'b0;
      fail_cnt_reg   <= '0;
    end else if (state_reg == ST_EVAL) begin
      fail_flags_reg <= fail_next;
      done_reg       <= 1'b1;
      if ((|fail_next) && (fail_cnt_reg != '1))
        fail_cnt_reg <= fail_cnt_reg + FCNT_W'(1);
    end else begin
      if (start_go)       done_reg       <= 1'b0;
      if (start_explicit) fail_flags_reg <= '0;
    end
  end

  // The TRO runs exactly while words are being collected.
  assign enable_TRO  = (state_reg == ST_COLLECT);
  assign done        = done_reg;
  assign fail_flags  = fail_flags_reg;
  assign stat_error  = |fail_flags_reg;
  assign fail_cnt    = fail_cnt_reg;
  assign debug_ones  = ones_acc_reg;
  assign debug_trans = trans_acc_reg;

endmodule
